// File: rtl/hog_cell_fetch.sv
// ---------------------------------------------------------------------------
// hog_cell_fetch
//
// Upstream feeder for the HOG-to-SVM stage. Collects a raster stream of
// CELL_S x CELL_S pixel windows (8x8 cell plus a 1-pixel gradient border),
// drops the four corner pixels and packs the remaining PIX_N pixels into one
// IN_W-bit word. Two banks are used: one is filled while the other waits for
// the HOG stage to fetch it.
//
// Optional feature (compile-time macro): HOG_FETCH_SOF_CHECK_EN
//   Defined   : i_sof is checked on every accepted pixel; framing errors set
//               the sticky o_err and a misplaced i_sof restarts the window.
//   Undefined : i_sof is ignored and o_err is constant 0.
//
// Ports
//   clk          in   1      single clock, rising edge
//   rst          in   1      asynchronous, active-low reset
//   i_valid      in   1      upstream pixel valid
//   i_pixel      in   PIX_W  upstream pixel, raster order within the window
//   i_sof        in   1      first pixel (row 0, col 0) of a window
//   o_in_ready   out  1      a pixel can be accepted this cycle
//   request      in   1      HOG stage wants a window (level)
//   ready        out  1      one-cycle strobe: i_data_fetch holds a new window
//   i_data_fetch out  IN_W   packed window, field k at [k*PIX_W +: PIX_W]
//   o_err        out  1      sticky framing error
//
// Handshakes
//   Upstream : a pixel transfers on a rising edge where i_valid && o_in_ready.
//              o_in_ready depends only on registered bank state, never on
//              i_valid.
//   Fetch    : a window transfers on a rising edge where request is high,
//              ready is low and the oldest bank is FULL; ready is the
//              registered strobe of that edge and drops on the next edge,
//              so transfers are at least two cycles apart.
// ---------------------------------------------------------------------------
module hog_cell_fetch #(
  parameter  int PIX_W  = 8,
  parameter  int CELL_S = 10,
  localparam int PIX_N  = CELL_S * CELL_S - 4,
  localparam int IN_W   = PIX_W * PIX_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [PIX_W-1:0] i_pixel,
  input  logic             i_sof,
  output logic             o_in_ready,
  input  logic             request,
  output logic             ready,
  output logic [IN_W-1:0]  i_data_fetch,
  output logic             o_err
);

  localparam int CNT_W = $clog2(CELL_S);
  localparam int K_W   = $clog2(PIX_N);
  localparam int B_W   = $clog2(IN_W);
  localparam logic [CNT_W-1:0] LAST_RC = CNT_W'(CELL_S - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  bank_state_t      r_state [2];
  logic [IN_W-1:0]  r_bank  [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic [K_W-1:0]   r_k;
  logic             r_ready;
  logic [IN_W-1:0]  r_data;
  logic             r_err;

  logic             w_accept;
  logic             w_xfer;
  logic             w_at_origin;
  logic             w_sof_restart;
  logic             w_sof_missing;
  logic [CNT_W-1:0] w_row_eff;
  logic [CNT_W-1:0] w_col_eff;
  logic [K_W-1:0]   w_k_eff;
  logic             w_corner;
  logic             w_last;
  logic [B_W-1:0]   w_base;

  assign o_in_ready   = (r_state[r_wr_ptr] != BANK_FULL);
  assign ready        = r_ready;
  assign i_data_fetch = r_data;
  assign o_err        = r_err;

  assign w_accept    = i_valid && o_in_ready;
  assign w_xfer      = request && !r_ready && (r_state[r_rd_ptr] == BANK_FULL);
  assign w_at_origin = (r_row == '0) && (r_col == '0);

`ifdef HOG_FETCH_SOF_CHECK_EN
  assign w_sof_restart = w_accept && i_sof && !w_at_origin;
  assign w_sof_missing = w_accept && !i_sof && w_at_origin;
`else
  logic w_unused_sof;
  assign w_unused_sof  = i_sof;
  assign w_sof_restart = 1'b0;
  assign w_sof_missing = 1'b0;
`endif

  // A misplaced start-of-frame pixel is treated as position (0,0) of a new
  // window, so the position used for this pixel is forced to the origin.
  assign w_row_eff = w_sof_restart ? '0 : r_row;
  assign w_col_eff = w_sof_restart ? '0 : r_col;
  assign w_k_eff   = w_sof_restart ? '0 : r_k;

  assign w_corner = ((w_row_eff == '0) || (w_row_eff == LAST_RC)) &&
                    ((w_col_eff == '0) || (w_col_eff == LAST_RC));
  assign w_last   = (w_row_eff == LAST_RC) && (w_col_eff == LAST_RC);
  assign w_base   = B_W'(w_k_eff) * B_W'(PIX_W);

  // Bank state, pointers, position counters and fetch outputs.
  // The transfer always touches the read bank (FULL) and an accepted pixel
  // always touches the write bank (not FULL), so both may happen on the same
  // edge without colliding on r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state[0] <= BANK_EMPTY;
      r_state[1] <= BANK_EMPTY;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_k        <= '0;
      r_ready    <= 1'b0;
      r_data     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_ready <= w_xfer;

      if (w_xfer) begin
        r_data            <= r_bank[r_rd_ptr];
        r_state[r_rd_ptr] <= BANK_EMPTY;
        r_rd_ptr          <= ~r_rd_ptr;
      end

      if (w_sof_restart || w_sof_missing) begin
        r_err <= 1'b1;
      end

      if (w_accept) begin
        if (w_last) begin
          r_state[r_wr_ptr] <= BANK_FULL;
          r_wr_ptr          <= ~r_wr_ptr;
          r_row             <= '0;
          r_col             <= '0;
          r_k               <= '0;
        end else begin
          r_state[r_wr_ptr] <= BANK_FILLING;
          if (w_col_eff == LAST_RC) begin
            r_col <= '0;
            r_row <= w_row_eff + CNT_W'(1);
          end else begin
            r_col <= w_col_eff + CNT_W'(1);
            r_row <= w_row_eff;
          end
          // Corners occupy no packed field, so the field index only advances
          // on non-corner pixels.
          r_k <= w_corner ? w_k_eff : w_k_eff + K_W'(1);
        end
      end
    end
  end

  // Pixel storage: pure datapath, contents are only meaningful while the
  // bank state says FILLING or FULL, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_accept && !w_corner) begin
      r_bank[r_wr_ptr][w_base +: PIX_W] <= i_pixel;
    end
  end

endmodule

// File: tb/tb_hog_cell_fetch.sv
// ---------------------------------------------------------------------------
// Testbench for hog_cell_fetch. A window-level reference model (queues of
// pixels and packed words) runs every cycle; table vectors, directed corner
// sequences and a randomized phase are applied on top of it.
// ---------------------------------------------------------------------------
module tb_hog_cell_fetch;

  localparam int PIX_W  = 8;
  localparam int CELL_S = 10;
  localparam int PIX_N  = CELL_S * CELL_S - 4;
  localparam int IN_W   = PIX_W * PIX_N;

`ifdef HOG_FETCH_SOF_CHECK_EN
  localparam logic FR_ERR = 1'b1;
  localparam int   FR_K0  = 51;
  localparam int   FR_K95 = 148;
`else
  localparam logic FR_ERR = 1'b0;
  localparam int   FR_K0  = 1;
  localparam int   FR_K95 = 98;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk;
  logic             rst;
  logic             i_valid;
  logic [PIX_W-1:0] i_pixel;
  logic             i_sof;
  logic             o_in_ready;
  logic             request;
  logic             ready;
  logic [IN_W-1:0]  i_data_fetch;
  logic             o_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hog_cell_fetch #(.PIX_W(PIX_W), .CELL_S(CELL_S)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_pixel      (i_pixel),
    .i_sof        (i_sof),
    .o_in_ready   (o_in_ready),
    .request      (request),
    .ready        (ready),
    .i_data_fetch (i_data_fetch),
    .o_err        (o_err)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int n_pulse = 0;

  // ---------------- check helpers ----------------
  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_word(input string nm, input logic [IN_W-1:0] act,
                            input logic [IN_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int field(input int k);
    return int'(i_data_fetch[k*PIX_W +: PIX_W]);
  endfunction

  // ---------------- reference model / scoreboard ----------------
  // A window is just the list of accepted pixels in raster order; completed
  // windows are packed (corners skipped) and queued oldest first. Two queued
  // windows means no storage is left.
  logic [PIX_W-1:0] cur_q[$];
  logic [IN_W-1:0]  exp_q[$];
  logic             m_ready;
  logic [IN_W-1:0]  m_data;
  logic             m_err;

  function automatic logic [IN_W-1:0] pack_cur();
    logic [IN_W-1:0] w;
    int k;
    int r;
    int c;
    w = '0;
    k = 0;
    for (int i = 0; i < CELL_S * CELL_S; i++) begin
      r = i / CELL_S;
      c = i % CELL_S;
      if ((r == 0 || r == CELL_S - 1) && (c == 0 || c == CELL_S - 1)) continue;
      w[k*PIX_W +: PIX_W] = cur_q[i];
      k++;
    end
    return w;
  endfunction

  always begin : monitor
    logic m_acc;
    logic m_xfer;
    @(posedge clk);
    if (!rst) begin
      cur_q.delete();
      exp_q.delete();
      m_ready = 1'b0;
      m_data  = '0;
      m_err   = 1'b0;
    end else begin
      m_acc  = i_valid && (exp_q.size() < 2);
      m_xfer = request && !m_ready && (exp_q.size() > 0);
      m_ready = m_xfer;
      if (m_xfer) m_data = exp_q.pop_front();
      if (m_acc) begin
`ifdef HOG_FETCH_SOF_CHECK_EN
        if (i_sof && cur_q.size() != 0) begin
          m_err = 1'b1;
          cur_q.delete();
        end else if (!i_sof && cur_q.size() == 0) begin
          m_err = 1'b1;
        end
`endif
        cur_q.push_back(i_pixel);
        if (cur_q.size() == CELL_S * CELL_S) begin
          exp_q.push_back(pack_cur());
          cur_q.delete();
        end
      end
    end
    #1;
    if (ready === 1'b1) n_pulse++;
    check_bit("in_ready", o_in_ready, exp_q.size() < 2);
    check_bit("ready", ready, m_ready);
    check_word("data", i_data_fetch, m_data);
    check_bit("err", o_err, m_err);
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic do_reset();
    rst     = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    request = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Offer one pixel and hold it until it is taken.
  task automatic push_pix(input logic [PIX_W-1:0] p, input logic sof);
    int t;
    t = 0;
    i_valid = 1'b1;
    i_pixel = p;
    i_sof   = sof;
    while (!o_in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      n_vec++;
      n_miss++;
      $display("FAIL push_timeout: got stalled %0d cycles expected under 1000", t);
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  // Continuous i_valid for a number of cycles, pixel value = accepted count.
  task automatic run_burst(input int cycles, input logic req, output int acc,
                           output int pulses, output int fall_at);
    int p0;
    p0      = n_pulse;
    request = req;
    acc     = 0;
    fall_at = -1;
    for (int i = 0; i < cycles; i++) begin
      if (!o_in_ready && fall_at < 0) fall_at = acc;
      i_valid = 1'b1;
      i_pixel = PIX_W'(acc);
      i_sof   = (acc % 100 == 0);
      if (o_in_ready) acc++;
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_sof   = 1'b0;
    repeat (4) @(negedge clk);
    pulses = n_pulse - p0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    int   cycles;
    logic req;
    int   exp_acc;
    int   exp_pulses;
    logic exp_in_ready;
  } vec_t;

  vec_t tbl[6];

  // ---------------- main sequence ----------------
  initial begin : main
    int acc;
    int pul;
    int fall;
    int p0;
    int cnt;
    int first_i;
    int second_i;
    int b0;
    int b1;
    logic ir;

    rst = 1'b0; i_valid = 1'b0; i_pixel = '0; i_sof = 1'b0; request = 1'b0;

    tbl[0] = '{100, 1'b1, 100, 1, 1'b1};
    tbl[1] = '{ 99, 1'b1,  99, 0, 1'b1};
    tbl[2] = '{150, 1'b0, 150, 0, 1'b1};
    tbl[3] = '{200, 1'b0, 200, 0, 1'b0};
    tbl[4] = '{250, 1'b0, 200, 0, 1'b0};
    tbl[5] = '{300, 1'b1, 300, 3, 1'b1};

    repeat (3) @(negedge clk);
    check_bit("rst_ready", ready, 1'b0);
    check_word("rst_data", i_data_fetch, '0);
    check_bit("rst_in_ready", o_in_ready, 1'b1);
    check_bit("rst_err", o_err, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      run_burst(tbl[v].cycles, tbl[v].req, acc, pul, fall);
      check_int($sformatf("tbl%0d_accepted", v), acc, tbl[v].exp_acc);
      check_int($sformatf("tbl%0d_pulses", v), pul, tbl[v].exp_pulses);
      check_bit($sformatf("tbl%0d_in_ready", v), o_in_ready, tbl[v].exp_in_ready);
    end

    // Single window, pixel value = raster index.
    do_reset();
    request = 1'b1;
    p0 = n_pulse;
    for (int i = 0; i < 100; i++) push_pix(PIX_W'(i), i == 0);
    check_bit("sw_ready_edge_n", ready, 1'b0);
    @(negedge clk);
    check_bit("sw_ready_edge_n1", ready, 1'b1);
    check_int("sw_k0", field(0), 1);
    check_int("sw_k7", field(7), 8);
    check_int("sw_k8", field(8), 10);
    check_int("sw_k95", field(95), 98);
    cnt = 0;
    for (int k = 0; k < PIX_N; k++)
      if (field(k) == 0 || field(k) == 9 || field(k) == 90 || field(k) == 99) cnt++;
    check_int("sw_corners_absent", cnt, 0);
    @(negedge clk);
    check_bit("sw_ready_clear", ready, 1'b0);
    check_int("sw_pulses", n_pulse - p0, 1);

    // Back-pressure then drain.
    do_reset();
    run_burst(250, 1'b0, acc, pul, fall);
    check_int("bp_accepted", acc, 200);
    check_int("bp_fall_at", fall, 200);
    check_bit("bp_in_ready_low", o_in_ready, 1'b0);
    request = 1'b1;
    cnt = 0; first_i = -1; second_i = -1; b0 = -1; b1 = -1; ir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready) begin
        if (cnt == 0) begin
          first_i = i; b0 = field(0); ir = o_in_ready;
        end else if (cnt == 1) begin
          second_i = i; b1 = field(0);
        end
        cnt++;
      end
    end
    check_int("bp_pulses", cnt, 2);
    check_int("bp_first_at", first_i, 0);
    check_int("bp_second_at", second_i, 2);
    check_int("bp_first_k0", b0, 1);
    check_int("bp_second_k0", b1, 101);
    check_bit("bp_in_ready_back", ir, 1'b1);

    // Last pixel of bank 1 on the same edge as the transfer of bank 0.
    do_reset();
    for (int i = 0; i < 199; i++) push_pix(PIX_W'(i), i % 100 == 0);
    request = 1'b1;
    push_pix(PIX_W'(199), 1'b0);
    check_bit("sim_ready0", ready, 1'b1);
    check_int("sim_k0_w0", field(0), 1);
    check_bit("sim_in_ready", o_in_ready, 1'b1);
    @(negedge clk);
    check_bit("sim_gap", ready, 1'b0);
    @(negedge clk);
    check_bit("sim_ready1", ready, 1'b1);
    check_int("sim_k0_w1", field(0), 101);
    check_int("sim_k95_w1", field(95), 198);
    p0 = n_pulse;
    for (int i = 200; i < 300; i++) push_pix(PIX_W'(i), i % 100 == 0);
    repeat (3) @(negedge clk);
    check_int("sim_w2_pulses", n_pulse - p0, 1);
    check_int("sim_k0_w2", field(0), 201);
    check_int("sim_k95_w2", field(95), 42);

    // Reset with one bank FULL and 37 pixels in the other.
    do_reset();
    request = 1'b1;
    for (int i = 0; i < 100; i++) push_pix(PIX_W'(i + 3), i == 0);
    repeat (3) @(negedge clk);
    request = 1'b0;
    for (int i = 0; i < 137; i++) push_pix(PIX_W'(i), i % 100 == 0);
    rst = 1'b0;
    #1;
    check_bit("mr_ready", ready, 1'b0);
    check_word("mr_data", i_data_fetch, '0);
    check_bit("mr_in_ready", o_in_ready, 1'b1);
    check_bit("mr_err", o_err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    request = 1'b1;
    p0 = n_pulse;
    for (int i = 0; i < 100; i++) push_pix(PIX_W'(i + 50), i == 0);
    repeat (5) @(negedge clk);
    check_int("mr_pulses", n_pulse - p0, 1);
    check_int("mr_k0", field(0), 51);

    // Start-of-frame pulsed at pixel 50.
    do_reset();
    request = 1'b1;
    p0 = n_pulse;
    for (int i = 0; i < 150; i++) begin
      push_pix(PIX_W'(i), (i == 0) || (i == 50));
      if (i == 49) check_bit("fr_err_before", o_err, 1'b0);
      if (i == 50) check_bit("fr_err_set", o_err, FR_ERR);
    end
    repeat (5) @(negedge clk);
    check_int("fr_pulses", n_pulse - p0, 1);
    check_int("fr_k0", field(0), FR_K0);
    check_int("fr_k95", field(95), FR_K95);
    check_bit("fr_err_sticky", o_err, FR_ERR);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1700) rst = 1'b0;
      if (i == 1703) rst = 1'b1;
      i_valid = ($urandom_range(0, 9) < 7);
      i_pixel = PIX_W'($urandom);
      i_sof   = ($urandom_range(0, 19) == 0);
      request = ((i / 400) % 3 == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_sof   = 1'b0;
    request = 1'b1;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    n_miss++;
    $display("FAIL watchdog: got no finish expected finish within 5 ms");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog expired");
  end

endmodule
